gppcu_instr_issue: RTL and testbench
====================================

Name: gppcu_instr_issue

Overview:
Instruction fetch/issue sequencer that feeds the GPPCU instruction decoder. Steps a PC through instruction memory for a host-given program length and reads each 32-bit word. It then presents the 5-bit opcode and the operand field to the decoder and execution lanes, one instruction at a time. Downstream stall (FPU busy, LDL/STL in flight) holds issue; a done pulse tells the host controller the kernel has finished.

Parameters:
IADDR_W, 10, instruction memory address width (program length up to 2^IADDR_W words)
INSTR_W, 32, instruction word width; opcode = [INSTR_W-1 -: 5]
OPC_W, 5, opcode width; must match decoder input width

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous active-high reset
iSTART  in  1  start-program strobe from host; sampled only in IDLE
iABORT  in  1  abandon program; return to IDLE, no done pulse
iLEN  in  IADDR_W+1  number of instructions to run; latched on accepted iSTART
oBUSY  out  1  high in every state except IDLE
oDONE  out  1  one-cycle pulse after last instruction retires from issue
oIMEM_RD  out  1  instruction memory read enable
oIMEM_ADDR  out  IADDR_W  read address (= PC)
iIMEM_DATA  in  INSTR_W  read data, valid exactly one cycle after oIMEM_RD
iSTALL  in  1  downstream not ready; holds current issue
oVALID  out  1  oOPC/oOPR carry a real instruction this cycle
oOPC  out  OPC_W  opcode to decoder; NOP (5'd0) whenever oVALID=0
oOPR  out  INSTR_W-OPC_W  operand field (IR[26:0]); zero whenever oVALID=0
oISSUED  out  IADDR_W+1  count of instructions issued in current/last run

Behaviour:
- One clock (iCLK); reset iRST is synchronous, active-high. All state registered.
- Reset values: state=IDLE, PC=0, IR=0, len=0, oBUSY=0, oDONE=0, oIMEM_RD=0, oIMEM_ADDR=0, oVALID=0, oOPC=NOP, oOPR=0, oISSUED=0.
- FSM states: IDLE, FETCH, WAIT, ISSUE, FIN.
- IDLE: on iSTART, latch len=iLEN, clear PC and oISSUED. If iLEN==0, go to FIN; otherwise go to FETCH.
- FETCH: oIMEM_RD=1, oIMEM_ADDR=PC for one cycle; then WAIT.
- WAIT: capture iIMEM_DATA into IR; then ISSUE.
- ISSUE: oVALID=1, oOPC=IR[31:27], oOPR=IR[26:0].
  - While iSTALL=1: stay in ISSUE with outputs stable; no PC change.
  - On a cycle with iSTALL=0, the instruction is consumed: PC++ and oISSUED++.
  - If PC+1==len, go to FIN; otherwise go to FETCH.
  - Minimum throughput: 1 instruction per 3 cycles.
- FIN: oDONE=1 for exactly one cycle, then IDLE. oISSUED holds until the next accepted iSTART.
- oOPC must be NOP outside ISSUE so the decoder emits an all-zero control word (no register write).
- iSTART while oBUSY=1 is ignored.
- iABORT in any non-IDLE state forces IDLE next cycle: oVALID=0, oIMEM_RD=0, no oDONE. iABORT has priority over iSTALL and over the ISSUE->FIN transition. iABORT and iSTART together in IDLE: the start is ignored.
- Reset mid-program behaves as abort plus a full return to reset values.
- iLEN=2^IADDR_W: PC wraps to 0 exactly when the last instruction retires; the comparison uses the IADDR_W+1-bit counter, so there is no early termination.
- Opcode values are not interpreted here: undefined opcodes are issued unchanged, and the decoder defaults them.

Decomposition:
- Shared package GPPCU_PARAMETERS.vh: opcode constants (NOP=0 etc.), OPC_W, INSTR_W, IADDR_W, FSM state encodings.
- No sub-module required. The PC/issue counter may be a small gppcu_pc_counter (load-clear, increment, terminal compare), but inline is acceptable.

Test Plan:
- iLEN=3, imem {MOV, ADI, NOP}, iSTALL=0 -> oVALID pulses at cycles 3, 6, 9 after start with oOPC=MOV, ADI, NOP; oDONE at cycle 10; oISSUED=3.
- iLEN=0 with iSTART -> oBUSY for 1 cycle, oDONE pulse, no oIMEM_RD, oVALID never high.
- iLEN=2, iSTALL held for 4 cycles during the first ISSUE (FMUL word 0x20000123) -> oOPC/oOPR stable for 5 cycles, PC unchanged, oISSUED=1 only after release.
- iABORT asserted during WAIT of instruction 2 of 5 -> IDLE next cycle, no oDONE, oISSUED=1; a new iSTART runs from PC=0.
- iRST pulsed mid-ISSUE -> every output equals its reset value on the next cycle; iSTART while busy -> ignored, len unchanged.
- IADDR_W=2, iLEN=4 -> addresses 0,1,2,3 read exactly once; oDONE after 4th issue; PC=0 afterwards.

Source files
------------

// File: rtl/gppcu_instr_issue_pkg.sv
// Shared widths, opcode constants and FSM state encoding for the GPPCU
// instruction fetch/issue sequencer.
package gppcu_instr_issue_pkg;

  localparam int DEF_IADDR_W = 10;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_OPC_W   = 5;

  localparam logic [4:0] OPC_NOP  = 5'd0;
  localparam logic [4:0] OPC_MOV  = 5'd1;
  localparam logic [4:0] OPC_ADI  = 5'd2;
  localparam logic [4:0] OPC_FADD = 5'd3;
  localparam logic [4:0] OPC_FMUL = 5'd4;
  localparam logic [4:0] OPC_LDL  = 5'd5;
  localparam logic [4:0] OPC_STL  = 5'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_FIN   = 3'd4
  } issue_state_t;

endpackage

// File: rtl/gppcu_instr_issue_if.sv
// Host control, instruction-memory read port and decoder issue bundle.
interface gppcu_instr_issue_if
  import gppcu_instr_issue_pkg::*;
#(
  parameter int IADDR_W = DEF_IADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W   = DEF_OPC_W
) ();

  logic                     iSTART;
  logic                     iABORT;
  logic [IADDR_W:0]         iLEN;
  logic                     oBUSY;
  logic                     oDONE;
  logic                     oIMEM_RD;
  logic [IADDR_W-1:0]       oIMEM_ADDR;
  logic [INSTR_W-1:0]       iIMEM_DATA;
  logic                     iSTALL;
  logic                     oVALID;
  logic [OPC_W-1:0]         oOPC;
  logic [INSTR_W-OPC_W-1:0] oOPR;
  logic [IADDR_W:0]         oISSUED;

  modport master (
    output iSTART, iABORT, iLEN, iIMEM_DATA, iSTALL,
    input  oBUSY, oDONE, oIMEM_RD, oIMEM_ADDR, oVALID, oOPC, oOPR, oISSUED
  );

  modport slave (
    input  iSTART, iABORT, iLEN, iIMEM_DATA, iSTALL,
    output oBUSY, oDONE, oIMEM_RD, oIMEM_ADDR, oVALID, oOPC, oOPR, oISSUED
  );

endinterface

// File: rtl/gppcu_instr_issue_pc.sv
// Program counter plus issued-instruction counter with terminal compare.
module gppcu_instr_issue_pc
  import gppcu_instr_issue_pkg::*;
#(
  parameter int IADDR_W = DEF_IADDR_W
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               clear,
  input  logic               inc,
  input  logic [IADDR_W:0]   len,
  output logic [IADDR_W-1:0] pc,
  output logic [IADDR_W:0]   issued,
  output logic               last
);

  logic [IADDR_W-1:0] pc_reg;
  logic [IADDR_W:0]   issued_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      pc_reg     <= '0;
      issued_reg <= '0;
    end else if (clear) begin
      pc_reg     <= '0;
      issued_reg <= '0;
    end else if (inc) begin
      pc_reg     <= pc_reg + IADDR_W'(1);
      issued_reg <= issued_reg + (IADDR_W+1)'(1);
    end
  end

  // The wide counter decides termination, so a full-depth program lets the
  // PC wrap to zero on its final retire without ending early.
  assign last   = ((issued_reg + (IADDR_W+1)'(1)) == len);
  assign pc     = pc_reg;
  assign issued = issued_reg;

endmodule

// File: rtl/gppcu_instr_issue.sv
// Fetch/issue sequencer: walks the PC over the program, reads each word and
// hands opcode/operand to the decoder one instruction at a time.
module gppcu_instr_issue
  import gppcu_instr_issue_pkg::*;
#(
  parameter int IADDR_W = DEF_IADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W   = DEF_OPC_W
) (
  input  logic         iCLK,
  input  logic         iRST,
  gppcu_instr_issue_if.slave bus
);

  issue_state_t       state_reg, state_next;
  logic [INSTR_W-1:0] ir_reg;
  logic [IADDR_W:0]   len_reg;
  logic               ir_load;
  logic               cnt_clear;
  logic               consume;
  logic               last;
  logic               issue_valid;
  logic [IADDR_W-1:0] pc;
  logic [IADDR_W:0]   issued;

  gppcu_instr_issue_pc #(.IADDR_W(IADDR_W)) u_pc (
    .clk    (iCLK),
    .srst   (iRST),
    .clear  (cnt_clear),
    .inc    (consume),
    .len    (len_reg),
    .pc     (pc),
    .issued (issued),
    .last   (last)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ir_reg  <= '0;
      len_reg <= '0;
    end else begin
      if (ir_load) begin
        ir_reg <= bus.iIMEM_DATA;
      end
      if (cnt_clear) begin
        len_reg <= bus.iLEN;
      end
    end
  end

  // Abort outranks stall and retire, so an aborted instruction is never counted.
  always_comb begin
    state_next = state_reg;
    ir_load    = 1'b0;
    cnt_clear  = 1'b0;
    consume    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.iSTART && !bus.iABORT) begin
          cnt_clear  = 1'b1;
          state_next = (bus.iLEN == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = bus.iABORT ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.iABORT) begin
          state_next = ST_IDLE;
        end else begin
          ir_load    = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.iABORT) begin
          state_next = ST_IDLE;
        end else if (!bus.iSTALL) begin
          consume    = 1'b1;
          state_next = last ? ST_FIN : ST_FETCH;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign issue_valid    = (state_reg == ST_ISSUE);
  assign bus.oBUSY      = (state_reg != ST_IDLE);
  assign bus.oDONE      = (state_reg == ST_FIN);
  assign bus.oIMEM_RD   = (state_reg == ST_FETCH);
  assign bus.oIMEM_ADDR = pc;
  assign bus.oVALID     = issue_valid;
  // Outside ISSUE the decoder must see NOP so it produces no register write.
  assign bus.oOPC       = issue_valid ? ir_reg[INSTR_W-1 -: OPC_W] : '0;
  assign bus.oOPR       = issue_valid ? ir_reg[INSTR_W-OPC_W-1:0] : '0;
  assign bus.oISSUED    = issued;

endmodule

// File: tb/tb_gppcu_instr_issue.sv
// Randomized bench for gppcu_instr_issue: programs of random length, stall
// and abort patterns scored against a queue-based expectation model.
module tb_gppcu_instr_issue;
  import gppcu_instr_issue_pkg::*;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gppcu_instr_issue_if #(.IADDR_W(AW)) bus ();

  gppcu_instr_issue #(.IADDR_W(AW)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  logic [31:0] imem [DEPTH];

  // Read data valid the cycle after the read strobe; garbage otherwise.
  always @(posedge clk) begin
    bus.iIMEM_DATA <= bus.oIMEM_RD ? imem[bus.oIMEM_ADDR] : $urandom;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] preset[$];
  int exp_issued   = 0;
  int exp_reads    = 0;
  int stall_cycles = 0;
  int done_seen    = 0;
  int cyc          = 0;
  int force_lo     = -1;
  int force_hi     = -1;
  bit exp_busy     = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare one cycle of outputs with the model; stall is the value the DUT
  // sees at the coming clock edge.
  task automatic sample(input bit stall);
    check("busy", bus.oBUSY, exp_busy);
    check("issued", bus.oISSUED, exp_issued);
    if (bus.oVALID) begin
      if (exp_q.size() == 0) begin
        check("valid_extra", bus.oVALID, 0);
      end else begin
        check("opc", bus.oOPC, exp_q[0][31:27]);
        check("opr", bus.oOPR, exp_q[0][26:0]);
        if (stall) begin
          stall_cycles++;
        end else begin
          check("issue_time", cyc, 3 * exp_issued + 3 + stall_cycles);
          void'(exp_q.pop_front());
          exp_issued++;
        end
      end
    end else begin
      check("nop_opc", bus.oOPC, 0);
      check("nop_opr", bus.oOPR, 0);
    end
    if (bus.oIMEM_RD) begin
      check("rd_addr", bus.oIMEM_ADDR, exp_reads % DEPTH);
      exp_reads++;
    end
    if (bus.oDONE) done_seen++;
  endtask

  task automatic run(input int len, input int stall_pct, input int abort_at, input bit poke_start);
    bit aborted;
    bit finished;
    bit stall;
    for (int i = 0; i < DEPTH; i++) imem[i] = $urandom;
    for (int i = 0; i < preset.size(); i++) imem[i] = preset[i];
    exp_q.delete();
    for (int k = 0; k < len; k++) exp_q.push_back(imem[k % DEPTH]);

    @(negedge clk);
    cyc = 0;
    bus.iSTART = 1'b1;
    bus.iLEN   = (AW+1)'(len);
    bus.iABORT = 1'b0;
    bus.iSTALL = 1'b0;
    sample(1'b0);

    @(negedge clk);
    cyc = 1;
    exp_busy = 1'b1;
    exp_issued = 0;
    exp_reads = 0;
    stall_cycles = 0;
    done_seen = 0;
    aborted = 1'b0;
    finished = 1'b0;
    while (cyc < 20 * len + 40) begin
      stall = ($urandom_range(99) < stall_pct) || (cyc >= force_lo && cyc <= force_hi);
      if (cyc == abort_at && bus.oBUSY && !bus.oDONE) begin
        bus.iABORT = 1'b1;
        stall = 1'b1;
      end
      if (poke_start && $urandom_range(3) == 0) begin
        bus.iSTART = 1'b1;
        bus.iLEN   = (AW+1)'($urandom_range(DEPTH));
      end else begin
        bus.iSTART = 1'b0;
      end
      bus.iSTALL = stall;
      sample(stall);
      if (bus.oDONE) begin
        check("done_time", cyc, 3 * len + 1 + stall_cycles);
        finished = 1'b1;
        break;
      end
      if (bus.iABORT) begin
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (!finished && !aborted) check("timeout", 0, 1);

    @(negedge clk);
    cyc++;
    bus.iSTART = 1'b0;
    bus.iABORT = 1'b0;
    bus.iSTALL = 1'b0;
    exp_busy = 1'b0;
    sample(1'b0);
    if (aborted) begin
      check("abort_no_done", done_seen, 0);
    end else begin
      check("done_count", done_seen, 1);
      check("issued_final", bus.oISSUED, len);
      check("pc_final", bus.oIMEM_ADDR, len % DEPTH);
      check("reads", exp_reads, len);
    end
    $display("[TB] run len=%0d stall_pct=%0d abort_at=%0d -> issued=%0d aborted=%0d cycles=%0d",
             len, stall_pct, abort_at, bus.oISSUED, aborted, cyc);
    preset.delete();
    force_lo = -1;
    force_hi = -1;
  endtask

  task automatic reset_mid_issue();
    int k;
    for (int i = 0; i < DEPTH; i++) imem[i] = $urandom;
    @(negedge clk);
    bus.iSTART = 1'b1;
    bus.iLEN   = (AW+1)'(5);
    bus.iSTALL = 1'b1;
    @(negedge clk);
    bus.iSTART = 1'b0;
    k = 0;
    while (!bus.oVALID && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("reach_issue", bus.oVALID, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.iSTALL = 1'b0;
    check("rst_busy", bus.oBUSY, 0);
    check("rst_done", bus.oDONE, 0);
    check("rst_rd", bus.oIMEM_RD, 0);
    check("rst_addr", bus.oIMEM_ADDR, 0);
    check("rst_valid", bus.oVALID, 0);
    check("rst_opc", bus.oOPC, 0);
    check("rst_opr", bus.oOPR, 0);
    check("rst_issued", bus.oISSUED, 0);
    exp_issued = 0;
    exp_busy = 1'b0;
    $display("[TB] reset mid-issue after %0d wait cycles", k);
  endtask

  task automatic abort_with_start_idle();
    @(negedge clk);
    bus.iSTART = 1'b1;
    bus.iABORT = 1'b1;
    bus.iLEN   = (AW+1)'(3);
    @(negedge clk);
    bus.iSTART = 1'b0;
    bus.iABORT = 1'b0;
    check("abort_start_busy", bus.oBUSY, 0);
    check("abort_start_rd", bus.oIMEM_RD, 0);
    check("abort_start_issued", bus.oISSUED, exp_issued);
    $display("[TB] start+abort in idle -> busy=%0d", bus.oBUSY);
  endtask

  initial begin
    rst = 1'b1;
    bus.iSTART = 1'b0;
    bus.iABORT = 1'b0;
    bus.iLEN   = '0;
    bus.iSTALL = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sample(1'b0);
    check("reset_done", bus.oDONE, 0);
    check("reset_rd", bus.oIMEM_RD, 0);
    check("reset_addr", bus.oIMEM_ADDR, 0);

    // Three-instruction program with no stalls.
    preset.push_back({OPC_MOV, 27'h0000011});
    preset.push_back({OPC_ADI, 27'h4000022});
    preset.push_back({OPC_NOP, 27'h0000000});
    run(3, 0, -1, 1'b0);

    run(0, 0, -1, 1'b0);

    // FMUL held by a 4-cycle stall in its first issue cycle.
    preset.push_back(32'h20000123);
    force_lo = 3;
    force_hi = 6;
    run(2, 0, -1, 1'b0);

    // Abort during the read of the second of five instructions, then rerun.
    run(5, 0, 5, 1'b0);
    run(5, 0, -1, 1'b0);

    reset_mid_issue();
    abort_with_start_idle();

    // Full-depth program: PC must wrap exactly at the last retire.
    run(DEPTH, 0, -1, 1'b0);
    run(DEPTH, 40, -1, 1'b1);

    for (int r = 0; r < 40; r++) begin
      run($urandom_range(DEPTH), $urandom_range(60),
          ($urandom_range(3) == 0) ? $urandom_range(20, 1) : -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
